// File: rtl/i2s_tx_param.sv
// Parametrised I2S / left-justified stereo transmitter with a one-deep valid/ready sample buffer.
// Optional macro I2S_TX_UNDERRUN_CNT_EN adds a saturating 16-bit underrun_count output.
module i2s_tx_param #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SLOT_W  = 16,
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned MODE    = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] left_data,
    input  logic [DATA_W-1:0] right_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              right_n_left,
    output logic              underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_count
`endif
);

    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned BC_W    = $clog2(FRAME_W);
    localparam int unsigned DC_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t            state, state_n;
    logic [DC_W-1:0]   div_cnt, div_n;
    logic [BC_W-1:0]   bit_cnt, bc_n, bc_inc_c, pos_c;
    logic              bclk_n, load_c, upd_c, take_c, accept_c;
    logic              rnl_c, lr_c, sdata_c;
    logic [DATA_W-1:0] hold_l, hold_r, cur_l, cur_r, word_l_c, word_r_c;
    logic [SLOT_W-1:0] slot_c;

    assign accept_c = sample_valid && sample_ready;
    assign take_c   = load_c && !sample_ready;

    // Run/idle state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next state, divider, bit counter and frame-load strobe
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bclk_n  = bclk;
        bc_n    = bit_cnt;
        load_c  = 1'b0;
        upd_c   = 1'b0;
        if (!enable) begin
            state_n = ST_IDLE;
            div_n   = '0;
            bclk_n  = 1'b0;
            bc_n    = '0;
        end else if (state == ST_IDLE) begin
            state_n = ST_RUN;
            div_n   = '0;
            bclk_n  = 1'b0;
            bc_n    = '0;
            load_c  = 1'b1;
            upd_c   = 1'b1;
        end else if (div_cnt == DC_W'(CLK_DIV - 1)) begin
            div_n  = '0;
            bclk_n = ~bclk;
            if (bclk) begin
                upd_c = 1'b1;
                if (bit_cnt == BC_W'(FRAME_W - 1)) begin
                    bc_n   = '0;
                    load_c = 1'b1;
                end else begin
                    bc_n = bit_cnt + 1'b1;
                end
            end
        end else begin
            div_n = div_cnt + 1'b1;
        end
    end

    // Output values for the bit that bc_n selects, using the freshly loaded pair on a load
    always_comb begin
        word_l_c = take_c ? hold_l : cur_l;
        word_r_c = take_c ? hold_r : cur_r;
        rnl_c    = (bc_n >= BC_W'(SLOT_W));
        pos_c    = rnl_c ? (bc_n - BC_W'(SLOT_W)) : bc_n;
        slot_c   = SLOT_W'(rnl_c ? word_r_c : word_l_c) << (SLOT_W - DATA_W);
        slot_c   = slot_c << pos_c;
        sdata_c  = slot_c[SLOT_W-1];
        bc_inc_c = (bc_n == BC_W'(FRAME_W - 1)) ? '0 : (bc_n + 1'b1);
        lr_c     = (MODE == 1) ? rnl_c : (bc_inc_c >= BC_W'(SLOT_W));
    end

    // Datapath: counters, pins, holding and last-sample registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt      <= '0;
            bit_cnt      <= '0;
            bclk         <= 1'b0;
            lrclk        <= 1'b0;
            sdata        <= 1'b0;
            right_n_left <= 1'b0;
            underrun     <= 1'b0;
            sample_ready <= 1'b1;
            hold_l       <= '0;
            hold_r       <= '0;
            cur_l        <= '0;
            cur_r        <= '0;
        end else begin
            div_cnt  <= div_n;
            bit_cnt  <= bc_n;
            bclk     <= bclk_n;
            underrun <= load_c && sample_ready;
            if (!enable) begin
                {lrclk, sdata, right_n_left} <= 3'b000;
            end else if (upd_c) begin
                lrclk        <= lr_c;
                sdata        <= sdata_c;
                right_n_left <= rnl_c;
            end
            if (take_c) begin
                cur_l        <= hold_l;
                cur_r        <= hold_r;
                sample_ready <= 1'b1;
            end
            // Accept needs an empty holding register, so it never collides with take_c
            if (accept_c) begin
                hold_l       <= left_data;
                hold_r       <= right_data;
                sample_ready <= 1'b0;
            end
        end
    end

`ifdef I2S_TX_UNDERRUN_CNT_EN
    // Saturating count of underrun pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_count <= '0;
        end else if (load_c && sample_ready && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2s_tx_param.sv
// Bench for i2s_tx_param: two configurations (default I2S, and 12-in-24 left-justified at CLK_DIV=1)
// driven by random handshakes; a per-clk monitor checks pins against a frame-level reference model.
module tb_i2s_tx_param;

    localparam int NI = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] ld [NI];
    logic [23:0] rd [NI];
    logic        valid [NI];
    logic        ready [NI];
    logic        bclk_o [NI];
    logic        lr_o [NI];
    logic        sd_o [NI];
    logic        rnl_o [NI];
    logic        ur_o [NI];
`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] cnt_o [NI];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    i2s_tx_param u0 (
        .clk(clk), .rst(rst), .enable(enable),
        .left_data(ld[0][15:0]), .right_data(rd[0][15:0]),
        .sample_valid(valid[0]), .sample_ready(ready[0]),
        .bclk(bclk_o[0]), .lrclk(lr_o[0]), .sdata(sd_o[0]),
        .right_n_left(rnl_o[0]), .underrun(ur_o[0])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_count(cnt_o[0])
`endif
    );

    i2s_tx_param #(.DATA_W(12), .SLOT_W(24), .CLK_DIV(1), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .enable(enable),
        .left_data(ld[1][11:0]), .right_data(rd[1][11:0]),
        .sample_valid(valid[1]), .sample_ready(ready[1]),
        .bclk(bclk_o[1]), .lrclk(lr_o[1]), .sdata(sd_o[1]),
        .right_n_left(rnl_o[1]), .underrun(ur_o[1])
`ifdef I2S_TX_UNDERRUN_CNT_EN
        , .underrun_count(cnt_o[1])
`endif
    );

    // Per-instance configuration
    function automatic int dw(input int i);  return (i == 0) ? 16 : 12; endfunction
    function automatic int sw(input int i);  return (i == 0) ? 16 : 24; endfunction
    function automatic int cdv(input int i); return (i == 0) ? 4 : 1;   endfunction
    function automatic int md(input int i);  return (i == 0) ? 0 : 1;   endfunction

    // Edge bookkeeping: inputs as the DUT saw them at the most recent rising clk
    int unsigned edge_n = 0;
    logic        en_e = 1'b0;
    logic        rst_e = 1'b1;
    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        en_e   <= enable;
        rst_e  <= rst;
    end

    // Reference model state: accepted pairs awaiting transmission, current frame pair
    logic [23:0] pl [NI][4];
    logic [23:0] pr [NI][4];
    int unsigned pe [NI][4];
    int          ph [NI];
    int          pc [NI];
    logic [23:0] cl [NI];
    logic [23:0] cr [NI];
    logic        running [NI];
    logic        pb [NI];
    int          hcnt [NI];
    int          bk [NI];
    logic        exp_ur [NI];
    int          ucnt [NI];

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t: got %h, expected %h", nm, i, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int i);
        pc[i] = 0; ph[i] = 0; cl[i] = '0; cr[i] = '0;
        running[i] = 1'b0; pb[i] = 1'b0; hcnt[i] = 0; bk[i] = 0;
        exp_ur[i] = 1'b0; ucnt[i] = 0;
    endtask

    // A frame takes a pair only if it was accepted strictly before the load clk
    task automatic do_load(input int i);
        if (pc[i] > 0 && pe[i][ph[i]] < edge_n) begin
            cl[i] = pl[i][ph[i]];
            cr[i] = pr[i][ph[i]];
            ph[i] = (ph[i] + 1) % 4;
            pc[i]--;
        end else begin
            exp_ur[i] = 1'b1;
            if (ucnt[i] < 65535) ucnt[i]++;
        end
    endtask

    task automatic check_bit(input int i);
        int s, d, k, p;
        logic ch, eb, elr;
        logic [23:0] smp;
        s   = sw(i);
        d   = dw(i);
        k   = bk[i];
        ch  = (k >= s);
        p   = ch ? k - s : k;
        smp = ch ? cr[i] : cl[i];
        eb  = (p < d) ? smp[5'(d - 1 - p)] : 1'b0;
        elr = (md(i) == 1) ? ch : (((k + 1) % (2 * s)) >= s);
        chk("sdata", i, 32'(sd_o[i]), 32'(eb));
        chk("right_n_left", i, 32'(rnl_o[i]), 32'(ch));
        chk("lrclk", i, 32'(lr_o[i]), 32'(elr));
    endtask

    task automatic mon(input int i);
        logic exp_rdy;
        exp_ur[i] = 1'b0;
        if (rst || rst_e) begin
            model_reset(i);
            return;
        end
        if (!en_e) begin
            running[i] = 1'b0;
            chk("idle_pins", i, 32'({bclk_o[i], lr_o[i], sd_o[i], rnl_o[i]}), 32'd0);
        end else if (!running[i]) begin
            running[i] = 1'b1;
            hcnt[i] = 0;
            bk[i] = 0;
            do_load(i);
            chk("start_bclk", i, 32'(bclk_o[i]), 32'd0);
        end else begin
            hcnt[i]++;
            if (bclk_o[i] != pb[i]) begin
                chk("half_period", i, 32'(hcnt[i]), 32'(cdv(i)));
                hcnt[i] = 0;
                if (bclk_o[i]) begin
                    check_bit(i);
                end else begin
                    bk[i]++;
                    if (bk[i] == 2 * sw(i)) begin
                        bk[i] = 0;
                        do_load(i);
                    end
                end
            end else if (hcnt[i] > cdv(i)) begin
                chk("bclk_stuck", i, 32'(hcnt[i]), 32'(cdv(i)));
                hcnt[i] = 0;
            end
        end
        pb[i] = bclk_o[i];
        chk("underrun", i, 32'(ur_o[i]), 32'(exp_ur[i]));
        exp_rdy = !(pc[i] > 0 && pe[i][ph[i]] <= edge_n);
        chk("sample_ready", i, 32'(ready[i]), 32'(exp_rdy));
`ifdef I2S_TX_UNDERRUN_CNT_EN
        chk("underrun_count", i, 32'(cnt_o[i]), 32'(ucnt[i]));
`endif
    endtask

    // Monitor: evaluates every clk, away from the active edge
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) mon(i);
    end

    // Offer n pairs on instance i; each accepted pair is pushed with its accept edge
    task automatic drv(input int i, input int n, input int gap, input bit first);
        logic [23:0] l, r, mask;
        int w;
        mask = (i == 0) ? 24'h00FFFF : 24'h000FFF;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(gap, 0)) @(negedge clk);
            if (first && k == 0) begin
                l = (i == 0) ? 24'h00F0F0 : 24'h000ABC;
                r = (i == 0) ? 24'h00AAAA : 24'h000555;
            end else begin
                l = 24'($urandom) & mask;
                r = 24'($urandom) & mask;
            end
            ld[i] = l;
            rd[i] = r;
            valid[i] = 1'b1;
            w = 0;
            while (!ready[i] && w < 2000) begin
                @(negedge clk);
                w++;
            end
            if (!ready[i]) begin
                chk("accept_timeout", i, 32'(ready[i]), 32'd1);
                valid[i] = 1'b0;
                return;
            end
            pl[i][(ph[i] + pc[i]) % 4] = l;
            pr[i][(ph[i] + pc[i]) % 4] = r;
            pe[i][(ph[i] + pc[i]) % 4] = edge_n + 1;
            pc[i]++;
            @(negedge clk);
            valid[i] = 1'b0;
            ld[i] = 24'($urandom) & mask;
            rd[i] = 24'($urandom) & mask;
        end
    endtask

    task automatic chk_reset();
        for (int i = 0; i < NI; i++) begin
            chk("rst_pins", i, 32'({bclk_o[i], lr_o[i], sd_o[i], rnl_o[i], ur_o[i]}), 32'd0);
            chk("rst_ready", i, 32'(ready[i]), 32'd1);
`ifdef I2S_TX_UNDERRUN_CNT_EN
            chk("rst_count", i, 32'(cnt_o[i]), 32'd0);
`endif
        end
    endtask

    initial begin
        for (int i = 0; i < NI; i++) begin
            ld[i] = '0;
            rd[i] = '0;
            valid[i] = 1'b0;
            model_reset(i);
        end
        #23;
        chk_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Known first pair preloaded while idle, then continuous random traffic
        fork
            drv(0, 1, 0, 1'b1);
            drv(1, 1, 0, 1'b1);
        join
        enable = 1'b1;
        fork
            drv(0, 12, 30, 1'b0);
            drv(1, 14, 20, 1'b0);
        join

        // Starve both transmitters so frames repeat and underrun pulses
        repeat (400) @(negedge clk);
        fork
            drv(0, 3, 10, 1'b0);
            drv(1, 3, 10, 1'b0);
        join
        repeat (300) @(negedge clk);

        // Abort mid-frame, load the holding register while idle, then restart
        repeat ($urandom_range(60, 10)) @(negedge clk);
        enable = 1'b0;
        fork
            drv(0, 1, 0, 1'b0);
            drv(1, 1, 0, 1'b0);
        join
        repeat (20) @(negedge clk);
        enable = 1'b1;
        fork
            drv(0, 4, 40, 1'b0);
            drv(1, 4, 40, 1'b0);
        join

        // Asynchronous reset pulse mid-run
        repeat ($urandom_range(50, 5)) @(negedge clk);
        #3 rst = 1'b1;
        #1 chk_reset();
        #15 rst = 1'b0;
        repeat (2) @(negedge clk);
        fork
            drv(0, 4, 20, 1'b0);
            drv(1, 4, 20, 1'b0);
        join
        repeat (300) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
